// File: rtl/binarize_bbox_pkg.sv
// Shared image-pipeline package.
// Holds the default coordinate widths, the gray pixel width and the
// state encoding of the bounding-box frame sequencer.
package binarize_bbox_pkg;

    localparam int DEF_X_W = 11;   // default column coordinate width
    localparam int DEF_Y_W = 11;   // default row coordinate width
    localparam int PIX_W   = 12;   // gray pixel / threshold width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_REPORT = 2'd2
    } bbox_state_t;

endpackage

// File: rtl/binarize_bbox_sync_edge_det.sv
// sync_edge_det: edge detector for a bundle of timing signals.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset (history cleared to 0)
//   sig   - N level signals
//   rise  - 1 in the cycle a signal is 1 after being 0 the cycle before
//   fall  - 1 in the cycle a signal is 0 after being 1 the cycle before
// The pulses are formed from the live input and a registered copy of the
// previous cycle, so they line up with the pixel presented in the same
// cycle as the edge.
module sync_edge_det #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sig,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= sig;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_edge
            assign rise[gi] = sig[gi] & ~prev_reg[gi];
            assign fall[gi] = ~sig[gi] & prev_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/binarize_bbox.sv
// binarize_bbox: thresholds a gray pixel stream and reports, once per frame,
// the bounding box and population of the foreground pixels.
// Ports:
//   clk, iRST_n                         - clock, synchronous active-low reset
//   i_y_12b, i_h_sync, i_v_sync,
//   i_data_en                           - gray pixel stream with timing
//   i_threshold                         - threshold, latched on v_sync rise
//   o_bin, o_h_sync, o_v_sync, o_data_en- binarized stream, 1 cycle latency
//   o_x_min/o_x_max/o_y_min/o_y_max     - bounding box of the last frame
//   o_pix_count, o_box_found            - foreground count / non-empty flag
//   o_box_valid                         - one-cycle pulse on box update
module binarize_bbox
    import binarize_bbox_pkg::*;
#(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W
) (
    input  logic                 clk,
    input  logic                 iRST_n,
    input  logic [PIX_W-1:0]     i_y_12b,
    input  logic                 i_h_sync,
    input  logic                 i_v_sync,
    input  logic                 i_data_en,
    input  logic [PIX_W-1:0]     i_threshold,
    output logic                 o_bin,
    output logic                 o_h_sync,
    output logic                 o_v_sync,
    output logic                 o_data_en,
    output logic [X_W-1:0]       o_x_min,
    output logic [X_W-1:0]       o_x_max,
    output logic [Y_W-1:0]       o_y_min,
    output logic [Y_W-1:0]       o_y_max,
    output logic [X_W+Y_W-1:0]   o_pix_count,
    output logic                 o_box_found,
    output logic                 o_box_valid
);

    localparam int C_W = X_W + Y_W;
    localparam logic [X_W-1:0] COL_SAT = '1;
    localparam logic [Y_W-1:0] ROW_SAT = '1;
    localparam logic [C_W-1:0] CNT_SAT = '1;

    // bit 0: v_sync, bit 1: data_en
    logic [1:0] edge_rise;
    logic [1:0] edge_fall;
    logic       vs_rise;
    logic       de_fall;

    sync_edge_det #(
        .N (2)
    ) u_edge (
        .clk   (clk),
        .rst_n (iRST_n),
        .sig   ({i_data_en, i_v_sync}),
        .rise  (edge_rise),
        .fall  (edge_fall)
    );

    assign vs_rise = edge_rise[0];
    assign de_fall = edge_fall[1];

    logic [PIX_W-1:0] thr_reg;
    logic [X_W-1:0]   col_reg;
    logic [Y_W-1:0]   row_reg;
    logic             fg;

    bbox_state_t      state_reg;
    logic [X_W-1:0]   run_x_min_reg, run_x_max_reg;
    logic [Y_W-1:0]   run_y_min_reg, run_y_max_reg;
    logic [C_W-1:0]   run_cnt_reg;

    logic [X_W-1:0]   base_x_min, base_x_max, x_min_next, x_max_next;
    logic [Y_W-1:0]   base_y_min, base_y_max, y_min_next, y_max_next;
    logic [C_W-1:0]   base_cnt, cnt_next;
    logic             run_has_fg;

    // The threshold register only moves on a v_sync rise, so the pixel in
    // that same cycle still uses the old frame's threshold.
    assign fg = i_data_en && (i_y_12b >= thr_reg);

    always_ff @(posedge clk) begin
        if (!iRST_n) begin
            thr_reg <= '0;
        end else if (vs_rise) begin
            thr_reg <= i_threshold;
        end
    end

    // Output stream pipeline: one register stage.
    always_ff @(posedge clk) begin
        if (!iRST_n) begin
            o_bin     <= 1'b0;
            o_h_sync  <= 1'b0;
            o_v_sync  <= 1'b0;
            o_data_en <= 1'b0;
        end else begin
            o_bin     <= fg;
            o_h_sync  <= i_h_sync;
            o_v_sync  <= i_v_sync;
            o_data_en <= i_data_en;
        end
    end

    // Current pixel coordinate is the counter value itself, so the first
    // pixel of a line is column 0 and the first line of a frame is row 0.
    always_ff @(posedge clk) begin
        if (!iRST_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            if (de_fall) begin
                col_reg <= '0;
            end else if (i_data_en && (col_reg != COL_SAT)) begin
                col_reg <= col_reg + 1'b1;
            end

            if (vs_rise) begin
                row_reg <= '0;
            end else if (de_fall && (row_reg != ROW_SAT)) begin
                row_reg <= row_reg + 1'b1;
            end
        end
    end

    // Next running values. In the report cycle the accumulators restart
    // from their empty values, but a foreground pixel arriving in that very
    // cycle already belongs to the new frame and must not be lost.
    always_comb begin
        base_x_min = run_x_min_reg;
        base_x_max = run_x_max_reg;
        base_y_min = run_y_min_reg;
        base_y_max = run_y_max_reg;
        base_cnt   = run_cnt_reg;
        if (state_reg == ST_REPORT) begin
            base_x_min = COL_SAT;
            base_x_max = '0;
            base_y_min = ROW_SAT;
            base_y_max = '0;
            base_cnt   = '0;
        end

        x_min_next = base_x_min;
        x_max_next = base_x_max;
        y_min_next = base_y_min;
        y_max_next = base_y_max;
        cnt_next   = base_cnt;
        if (fg) begin
            if (col_reg < base_x_min) x_min_next = col_reg;
            if (col_reg > base_x_max) x_max_next = col_reg;
            if (row_reg < base_y_min) y_min_next = row_reg;
            if (row_reg > base_y_max) y_max_next = row_reg;
            if (base_cnt != CNT_SAT)  cnt_next   = base_cnt + 1'b1;
        end
    end

    assign run_has_fg = (run_cnt_reg != '0);

    // Frame sequencer with registered box outputs.
    always_ff @(posedge clk) begin
        if (!iRST_n) begin
            state_reg     <= ST_IDLE;
            run_x_min_reg <= COL_SAT;
            run_x_max_reg <= '0;
            run_y_min_reg <= ROW_SAT;
            run_y_max_reg <= '0;
            run_cnt_reg   <= '0;
            o_x_min       <= '0;
            o_x_max       <= '0;
            o_y_min       <= '0;
            o_y_max       <= '0;
            o_pix_count   <= '0;
            o_box_found   <= 1'b0;
            o_box_valid   <= 1'b0;
        end else begin
            o_box_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Partial frame after reset: wait for a clean start.
                    if (vs_rise) state_reg <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    run_x_min_reg <= x_min_next;
                    run_x_max_reg <= x_max_next;
                    run_y_min_reg <= y_min_next;
                    run_y_max_reg <= y_max_next;
                    run_cnt_reg   <= cnt_next;
                    if (vs_rise) state_reg <= ST_REPORT;
                end
                ST_REPORT: begin
                    o_x_min     <= run_has_fg ? run_x_min_reg : '0;
                    o_x_max     <= run_has_fg ? run_x_max_reg : '0;
                    o_y_min     <= run_has_fg ? run_y_min_reg : '0;
                    o_y_max     <= run_has_fg ? run_y_max_reg : '0;
                    o_pix_count <= run_cnt_reg;
                    o_box_found <= run_has_fg;
                    o_box_valid <= 1'b1;
                    run_x_min_reg <= x_min_next;
                    run_x_max_reg <= x_max_next;
                    run_y_min_reg <= y_min_next;
                    run_y_max_reg <= y_max_next;
                    run_cnt_reg   <= cnt_next;
                    state_reg     <= ST_ACTIVE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
